// File: rtl/weight_fetch_sequencer.sv
// Weight-fetch request sequencer: walks every (id, od-pair) of a layer with a valid/ready handshake.
// Define WSEQ_OD_OUTER_EN to swap the walk order to od outer, id inner.
module weight_fetch_sequencer #(
    parameter int unsigned OD_W = 8,
    parameter int unsigned ID_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [OD_W-1:0] total_od_i,
    input  logic [ID_W-1:0] total_id_i,
    input  logic            ready_i,
    output logic [OD_W-1:0] weight_od1_o,
    output logic [ID_W-1:0] weight_id_o,
    output logic            weight_main_valid_o,
    output logic            od2_valid_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q;
    logic [OD_W-1:0] tot_od_q, od_q;
    logic [ID_W-1:0] tot_id_q, id_q;
    logic            valid_q, od2_valid_q, busy_q, done_q;

    logic [OD_W:0]   od_plus2;
    logic [ID_W:0]   id_plus1;
    logic            od_last, id_last;
    logic [OD_W-1:0] od_nxt;
    logic [ID_W-1:0] id_nxt;
    logic            seq_end, od2_nxt;

    // One extra bit so od+2 never wraps before the compare against the total.
    assign od_plus2 = {1'b0, od_q} + (OD_W+1)'(2);
    assign id_plus1 = {1'b0, id_q} + (ID_W+1)'(1);
    assign od_last  = od_plus2 >= {1'b0, tot_od_q};
    assign id_last  = id_plus1 == {1'b0, tot_id_q};

    always_comb begin
        od_nxt  = od_q;
        id_nxt  = id_q;
        seq_end = 1'b0;
`ifdef WSEQ_OD_OUTER_EN
        if (id_last) begin
            id_nxt  = '0;
            seq_end = od_last;
            if (!od_last) od_nxt = od_plus2[OD_W-1:0];
        end else begin
            id_nxt = id_plus1[ID_W-1:0];
        end
`else
        if (od_last) begin
            od_nxt  = '0;
            id_nxt  = id_plus1[ID_W-1:0];
            seq_end = id_last;
        end else begin
            od_nxt = od_plus2[OD_W-1:0];
        end
`endif
        od2_nxt = (({1'b0, od_nxt} + (OD_W+1)'(1)) < {1'b0, tot_od_q}) && !seq_end;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            tot_od_q    <= '0;
            tot_id_q    <= '0;
            od_q        <= '0;
            id_q        <= '0;
            valid_q     <= 1'b0;
            od2_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        tot_od_q <= total_od_i;
                        tot_id_q <= total_id_i;
                        od_q     <= '0;
                        id_q     <= '0;
                        busy_q   <= 1'b1;
                        if (total_od_i == '0 || total_id_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= StRun;
                            valid_q     <= 1'b1;
                            od2_valid_q <= total_od_i > OD_W'(1);
                        end
                    end
                end
                StRun: begin
                    if (ready_i) begin
                        od_q        <= od_nxt;
                        id_q        <= id_nxt;
                        od2_valid_q <= od2_nxt;
                        if (seq_end) begin
                            state_q <= StDrain;
                            valid_q <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign weight_od1_o        = od_q;
    assign weight_id_o         = id_q;
    assign weight_main_valid_o = valid_q;
    assign od2_valid_o         = od2_valid_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: request-list model plus per-cycle compare, randomized stimulus.
module tb_weight_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] total_od_i = '0;
    logic [3:0] total_id_i = '0;
    logic       ready_i = 1'b1;
    logic [7:0] weight_od1_o;
    logic [3:0] weight_id_o;
    logic       weight_main_valid_o, od2_valid_o, busy_o, done_o;

    weight_fetch_sequencer #(.OD_W(8), .ID_W(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_i             (start_i),
        .total_od_i          (total_od_i),
        .total_id_i          (total_id_i),
        .ready_i             (ready_i),
        .weight_od1_o        (weight_od1_o),
        .weight_id_o         (weight_id_o),
        .weight_main_valid_o (weight_main_valid_o),
        .od2_valid_o         (od2_valid_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected request list for a layer, straight from the loop-order rules.
    int exp_od[$];
    int exp_id[$];
    int exp_o2[$];
    int nreq;

    task automatic build(input int tod, input int tid);
        exp_od.delete(); exp_id.delete(); exp_o2.delete();
`ifdef WSEQ_OD_OUTER_EN
        for (int od = 0; od < tod; od += 2)
            for (int id = 0; id < tid; id++) begin
                exp_od.push_back(od); exp_id.push_back(id); exp_o2.push_back(int'(od + 1 < tod));
            end
`else
        for (int id = 0; id < tid; id++)
            for (int od = 0; od < tod; od += 2) begin
                exp_od.push_back(od); exp_id.push_back(id); exp_o2.push_back(int'(od + 1 < tod));
            end
`endif
        nreq = exp_od.size();
    endtask

    // Ready driver: random or manual, applied shortly after each rising edge.
    bit rdy_rand = 1'b0;
    bit rdy_man  = 1'b1;
    always @(posedge clk) begin
        #2;
        ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_man;
    end

    // Compare process: mode 0 idle, 1 run, 2 drain, 3 done.
    int mode = 0;
    int idx = 0;
    int cyc = 0;
    int start_cyc = 0;
    int stalls = 0;
    int last_lat = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_valid", int'(weight_main_valid_o), 0);
            check("rst_od1", int'(weight_od1_o), 0);
            check("rst_id", int'(weight_id_o), 0);
            check("rst_od2", int'(od2_valid_o), 0);
            check("rst_busy", int'(busy_o), 0);
            check("rst_done", int'(done_o), 0);
            mode = 0;
        end else begin
            if (done_o) done_cnt++;
            check("valid", int'(weight_main_valid_o), int'(mode == 1));
            check("busy", int'(busy_o), int'(mode != 0));
            check("done", int'(done_o), int'(mode == 3));
            if (mode == 1) begin
                if (idx < nreq) begin
                    check("od1", int'(weight_od1_o), exp_od[idx]);
                    check("id", int'(weight_id_o), exp_id[idx]);
                    check("od2_valid", int'(od2_valid_o), exp_o2[idx]);
                end else begin
                    check("extra_request", idx, nreq - 1);
                end
            end
            if (mode == 3) begin
                last_lat = cyc - start_cyc;
                check("done_latency", last_lat, (nreq == 0) ? 1 : nreq + 2 + stalls);
            end
            case (mode)
                0: if (start_i) begin
                    build(int'(total_od_i), int'(total_id_i));
                    idx = 0; stalls = 0; start_cyc = cyc;
                    mode = (nreq == 0) ? 3 : 1;
                end
                1: if (ready_i) begin
                    idx++;
                    if (idx >= nreq) mode = 2;
                end else begin
                    stalls++;
                end
                2: mode = 3;
                default: mode = 0;
            endcase
        end
        cyc++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_start(input int tod, input int tid);
        total_od_i = 8'(tod);
        total_id_i = 4'(tid);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        check("done_seen", int'(done_cnt != d0), 1);
        tick(2);
    endtask

    int lit_od[4];
    int lit_id[4];

    initial begin
        // Pin the model against hand-written request lists.
        build(4, 2);
`ifdef WSEQ_OD_OUTER_EN
        lit_od = '{0, 0, 2, 2};
        lit_id = '{0, 1, 0, 1};
`else
        lit_od = '{0, 2, 0, 2};
        lit_id = '{0, 0, 1, 1};
`endif
        check("pin_n_4x2", nreq, 4);
        for (int i = 0; i < 4; i++) begin
            check("pin_od_4x2", exp_od[i], lit_od[i]);
            check("pin_id_4x2", exp_id[i], lit_id[i]);
            check("pin_o2_4x2", exp_o2[i], 1);
        end
        build(5, 1);
        check("pin_n_5x1", nreq, 3);
        check("pin_o2_last", exp_o2[2], 0);
        check("pin_od_last", exp_od[2], 4);
        nreq = 0;

        tick(3);
        reset = 1'b1;
        tick(2);

        // Even od, ready high: done 6 cycles after the start-pulse cycle.
        do_start(4, 2);
        wait_done(50);
        check("lat_4x2", last_lat, 6);

        // Odd od.
        do_start(5, 1);
        wait_done(50);
        check("lat_5x1", last_lat, 5);

        // Backpressure: 3 stall cycles mid-sequence.
        do_start(7, 2);
        tick(2);
        rdy_man = 1'b0;
        tick(3);
        rdy_man = 1'b1;
        wait_done(80);
        check("lat_stall", last_lat, 8 + 2 + 3);

        // Zero totals.
        do_start(6, 0);
        wait_done(10);
        check("lat_zero_id", last_lat, 1);
        do_start(0, 3);
        wait_done(10);

        // Start during RUN is ignored.
        do_start(6, 3);
        tick(2);
        total_od_i = 8'd2;
        total_id_i = 4'd1;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        wait_done(80);
        check("lat_ignored_start", last_lat, 11);

        // Reset mid-run, then a fresh start from (0,0).
        begin
            int d0;
            d0 = done_cnt;
            do_start(8, 3);
            tick(4);
            reset = 1'b0;
            tick(2);
            reset = 1'b1;
            tick(3);
            check("no_done_after_reset", done_cnt, d0);
        end
        do_start(3, 2);
        wait_done(50);

        // Randomized layers with random backpressure.
        rdy_rand = 1'b1;
        for (int t = 0; t < 12; t++) begin
            do_start($urandom_range(0, 11), $urandom_range(0, 5));
            wait_done(400);
        end
        rdy_rand = 1'b0;
        rdy_man = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
